uart_receiver: RTL and testbench

//  Serial-to-parallel UART receiver: the stage downstream of the UART transmitter, consuming its serial line.

---
 rtl/uart_receiver.sv | 217 +++++++++++++++++++++
 tb/tb_uart_receiver.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampling 8-bit UART receiver feeding a
// first-word-fall-through receive FIFO.
// Optional feature macro: UART_RX_PARITY_EN (start + 8 data + even parity +
// stop). Without it frames are 8N1 and parity_error_o is tied low.
module uart_receiver #(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic                        clock_i,
   input  logic                        reset_i,
   input  logic                        uart_rx_i,
   input  logic [1:0]                  baudrate_select_i,
   input  logic                        data_read_i,
   output logic [7:0]                  data_o,
   output logic                        empty_o,
   output logic [$clog2(FIFO_DEPTH):0] fill_level_o,
   output logic                        frame_error_o,
   output logic                        overrun_error_o,
   output logic                        parity_error_o
);
   localparam int AW         = $clog2(FIFO_DEPTH);
   localparam int RAW_9600   = CLK_FREQ_HZ / (16 * 9600);
   localparam int RAW_19200  = CLK_FREQ_HZ / (16 * 19200);
   localparam int RAW_57600  = CLK_FREQ_HZ / (16 * 57600);
   localparam int RAW_115200 = CLK_FREQ_HZ / (16 * 115200);
   localparam int DIV_9600   = (RAW_9600   < 1) ? 1 : RAW_9600;
   localparam int DIV_19200  = (RAW_19200  < 1) ? 1 : RAW_19200;
   localparam int DIV_57600  = (RAW_57600  < 1) ? 1 : RAW_57600;
   localparam int DIV_115200 = (RAW_115200 < 1) ? 1 : RAW_115200;
   localparam logic [AW:0] FULL_LEVEL = FIFO_DEPTH[AW:0];

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   logic          r_sync1, r_rx_s, r_rx_d;
   logic [15:0]   r_tick_cnt;
   logic [1:0]    r_baud_sel;
   logic [1:0]    w_sel;
   logic [15:0]   w_div;
   logic          w_tick;
   state_t        r_state, w_state_next;
   logic [3:0]    r_s;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shift;
   logic          w_mid_bit, w_shift_en, w_stop_sample, w_frame_err, w_push;
`ifdef UART_RX_PARITY_EN
   logic          r_par_err, w_par_sample, w_par_fail;
`endif
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr, w_rd_ptr_next;
   logic [AW:0]   r_count;
   logic [7:0]    r_head;
   logic          w_full, w_pop_ok, w_push_ok, w_overrun;

   // Two-stage synchronizer plus a delayed copy for falling-edge detection.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         r_sync1 <= 1'b1;
         r_rx_s  <= 1'b1;
         r_rx_d  <= 1'b1;
      end else begin
         r_sync1 <= uart_rx_i;
         r_rx_s  <= r_sync1;
         r_rx_d  <= r_rx_s;
      end
   end

   // Divisor follows the live selection only while idle; a frame uses the latched copy.
   assign w_sel  = (r_state == S_IDLE) ? baudrate_select_i : r_baud_sel;
   assign w_tick = (r_tick_cnt >= (w_div - 16'd1));

   // Divisor lookup for the active baud selection.
   always_comb begin
      w_div = 16'(DIV_115200);
      case (w_sel)
         2'b00:   w_div = 16'(DIV_9600);
         2'b01:   w_div = 16'(DIV_19200);
         2'b10:   w_div = 16'(DIV_57600);
         default: w_div = 16'(DIV_115200);
      endcase
   end

   // Free-running 16x tick counter; baud selection captured as a frame starts.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         r_tick_cnt <= '0;
         r_baud_sel <= 2'b00;
      end else begin
         r_tick_cnt <= w_tick ? 16'd0 : r_tick_cnt + 16'd1;
         if (r_state == S_IDLE && w_state_next == S_START)
            r_baud_sel <= baudrate_select_i;
      end
   end

   // FSM state register.
   always_ff @(posedge clock_i) begin
      if (reset_i) r_state <= S_IDLE;
      else         r_state <= w_state_next;
   end

   // FSM next-state logic: start-bit qualification at mid-bit, then 16 ticks per bit.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (r_rx_d && !r_rx_s) w_state_next = S_START;
         S_START: if (w_tick && r_s == 4'd7) w_state_next = r_rx_s ? S_IDLE : S_DATA;
         S_DATA: begin
            if (w_tick && r_s == 4'd15 && r_bit_idx == 3'd7)
`ifdef UART_RX_PARITY_EN
               w_state_next = S_PARITY;
`else
               w_state_next = S_STOP;
`endif
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: if (w_tick && r_s == 4'd15) w_state_next = S_STOP;
`endif
         S_STOP:  if (w_tick && r_s == 4'd15) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // FSM outputs: mid-bit sample strobes and stop-bit verdicts.
   always_comb begin
      w_mid_bit     = w_tick && (r_s == 4'd15);
      w_shift_en    = 1'b0;
      w_stop_sample = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_sample  = 1'b0;
`endif
      case (r_state)
         S_DATA:   w_shift_en    = w_mid_bit;
`ifdef UART_RX_PARITY_EN
         S_PARITY: w_par_sample  = w_mid_bit;
`endif
         S_STOP:   w_stop_sample = w_mid_bit;
         default:  ;
      endcase
      w_frame_err = w_stop_sample && !r_rx_s;
`ifdef UART_RX_PARITY_EN
      w_push      = w_stop_sample && r_rx_s && !r_par_err;
      w_par_fail  = w_stop_sample && r_rx_s && r_par_err;
`else
      w_push      = w_stop_sample && r_rx_s;
`endif
   end

   // Sample counter, bit index and LSB-first shift register.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         r_s       <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
      end else begin
         if (r_state == S_IDLE) begin
            r_s       <= '0;
            r_bit_idx <= '0;
         end else if (w_tick) begin
            if (r_state == S_START && r_s == 4'd7) r_s <= '0;
            else                                   r_s <= r_s + 4'd1;
         end
         if (w_shift_en) begin
            r_shift   <= {r_rx_s, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   // Even-parity mismatch held until the stop bit decides the frame's fate.
   always_ff @(posedge clock_i) begin
      if (reset_i || r_state == S_IDLE) r_par_err <= 1'b0;
      else if (w_par_sample)            r_par_err <= r_rx_s ^ (^r_shift);
   end
`endif

   assign w_full        = (r_count == FULL_LEVEL);
   assign w_pop_ok      = data_read_i && (r_count != '0);
   assign w_push_ok     = w_push && (!w_full || w_pop_ok);
   assign w_overrun     = w_push && w_full && !w_pop_ok;
   assign w_rd_ptr_next = w_pop_ok ? r_rd_ptr + AW'(1) : r_rd_ptr;

   // Byte storage, written on accepted pushes; no reset so it maps onto RAM.
   always_ff @(posedge clock_i) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= r_shift;
   end

   // Pointers, level and registered head; bypass when the push lands at the new head.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_head   <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
         r_rd_ptr <= w_rd_ptr_next;
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: ;
         endcase
         if (w_push_ok && (r_wr_ptr == w_rd_ptr_next)) r_head <= r_shift;
         else                                          r_head <= r_mem[w_rd_ptr_next];
      end
   end

   assign data_o          = r_head;
   assign empty_o         = (r_count == '0);
   assign fill_level_o    = r_count;
   assign frame_error_o   = w_frame_err && !reset_i;
   assign overrun_error_o = w_overrun && !reset_i;
`ifdef UART_RX_PARITY_EN
   assign parity_error_o  = w_par_fail && !reset_i;
`else
   assign parity_error_o  = 1'b0;
`endif
endmodule

// File: tb/tb_uart_receiver.sv
// Directed testbench for uart_receiver at CLK_FREQ_HZ=1_843_200
// (16 clocks per bit at 115200, 192 clocks per bit at 9600).
module tb_uart_receiver;
   localparam int CLK_FREQ_HZ = 1_843_200;
   localparam int FIFO_DEPTH  = 16;
   localparam int FW          = $clog2(FIFO_DEPTH) + 1;
   localparam int FAST        = 16;
   localparam int SLOW        = 192;

   logic          clock_i = 1'b0;
   logic          reset_i = 1'b1;
   logic          uart_rx_i = 1'b1;
   logic [1:0]    baudrate_select_i = 2'b11;
   logic          data_read_i = 1'b0;
   logic [7:0]    data_o;
   logic          empty_o;
   logic [FW-1:0] fill_level_o;
   logic          frame_error_o, overrun_error_o, parity_error_o;

   int checks = 0;
   int failures = 0;
   int n_frame = 0;
   int n_over = 0;
   int n_par = 0;

   uart_receiver #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clock_i(clock_i), .reset_i(reset_i), .uart_rx_i(uart_rx_i),
      .baudrate_select_i(baudrate_select_i), .data_read_i(data_read_i),
      .data_o(data_o), .empty_o(empty_o), .fill_level_o(fill_level_o),
      .frame_error_o(frame_error_o), .overrun_error_o(overrun_error_o),
      .parity_error_o(parity_error_o)
   );

   always #5 clock_i = ~clock_i;

   // Count cycles each error output is high, so a single-cycle pulse adds exactly 1.
   always @(negedge clock_i) begin
      if (frame_error_o)   n_frame <= n_frame + 1;
      if (overrun_error_o) n_over  <= n_over + 1;
      if (parity_error_o)  n_par   <= n_par + 1;
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clock_i);
   endtask

   task automatic drive_bit(input logic v, input int bclk);
      uart_rx_i = v;
      repeat (bclk) @(negedge clock_i);
   endtask

   // One full frame; optionally switches the baud selection just before data bit chg_bit.
   task automatic send_frame(input logic [7:0] d, input int bclk, input logic stop_v,
                             input logic par_v, input int chg_bit, input logic [1:0] chg_sel);
      drive_bit(1'b0, bclk);
      for (int i = 0; i < 8; i++) begin
         if (i == chg_bit) baudrate_select_i = chg_sel;
         drive_bit(d[i], bclk);
      end
`ifdef UART_RX_PARITY_EN
      drive_bit(par_v, bclk);
`else
      if (par_v === 1'bx) uart_rx_i = 1'b1;
`endif
      drive_bit(stop_v, bclk);
   endtask

   task automatic send(input logic [7:0] d, input int bclk);
      send_frame(d, bclk, 1'b1, ^d, -1, 2'b00);
   endtask

   task automatic pop();
      data_read_i = 1'b1;
      @(negedge clock_i);
      data_read_i = 1'b0;
   endtask

   task automatic test_reset();
      reset_i = 1'b1; uart_rx_i = 1'b1; data_read_i = 1'b0; baudrate_select_i = 2'b11;
      idle(3);
      checks++; if (data_o !== 8'h00) begin failures++; $display("FAIL reset_data: got %h expected 00", data_o); end
      checks++; if (empty_o !== 1'b1) begin failures++; $display("FAIL reset_empty: got %b expected 1", empty_o); end
      checks++; if (fill_level_o !== 5'd0) begin failures++; $display("FAIL reset_fill: got %0d expected 0", fill_level_o); end
      checks++; if ({frame_error_o, overrun_error_o, parity_error_o} !== 3'b000) begin
         failures++; $display("FAIL reset_errs: got %b expected 000", {frame_error_o, overrun_error_o, parity_error_o}); end
      reset_i = 1'b0;
      idle(4);
      $display("test_reset done");
   endtask

   task automatic test_single();
      int f0, o0, p0;
      f0 = n_frame; o0 = n_over; p0 = n_par;
      baudrate_select_i = 2'b11;
      send(8'hA5, FAST);
      idle(4);
      checks++; if (data_o !== 8'hA5) begin failures++; $display("FAIL single_data: got %h expected a5", data_o); end
      checks++; if (empty_o !== 1'b0) begin failures++; $display("FAIL single_empty: got %b expected 0", empty_o); end
      checks++; if (fill_level_o !== 5'd1) begin failures++; $display("FAIL single_fill: got %0d expected 1", fill_level_o); end
      checks++; if ((n_frame - f0) + (n_over - o0) + (n_par - p0) !== 0) begin
         failures++; $display("FAIL single_errs: got %0d pulses expected 0", (n_frame - f0) + (n_over - o0) + (n_par - p0)); end
      pop();
      checks++; if (empty_o !== 1'b1) begin failures++; $display("FAIL single_pop_empty: got %b expected 1", empty_o); end
      $display("test_single: rx a5 data=%h", 8'hA5);
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_b [3];
      exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h3C;
      baudrate_select_i = 2'b00;
      for (int i = 0; i < 3; i++) send(exp_b[i], SLOW);
      idle(20);
      checks++; if (fill_level_o !== 5'd3) begin failures++; $display("FAIL b2b_fill: got %0d expected 3", fill_level_o); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (data_o !== exp_b[i]) begin failures++; $display("FAIL b2b_data%0d: got %h expected %h", i, data_o, exp_b[i]); end
         pop();
      end
      checks++; if (empty_o !== 1'b1) begin failures++; $display("FAIL b2b_empty: got %b expected 1", empty_o); end
      $display("test_back_to_back: 3 bytes at 9600");
   endtask

   task automatic test_baud_latch();
      int f0;
      f0 = n_frame;
      baudrate_select_i = 2'b00;
      send_frame(8'hC3, SLOW, 1'b1, ^8'hC3, 2, 2'b11);
      idle(20);
      checks++; if (data_o !== 8'hC3 || fill_level_o !== 5'd1) begin
         failures++; $display("FAIL baud_latch: got data=%h fill=%0d expected c3/1", data_o, fill_level_o); end
      checks++; if (n_frame - f0 !== 0) begin failures++; $display("FAIL baud_latch_frame: got %0d expected 0", n_frame - f0); end
      pop();
      baudrate_select_i = 2'b11;
      $display("test_baud_latch: mid-frame select change ignored");
   endtask

   task automatic test_glitch();
      int f0;
      f0 = n_frame;
      uart_rx_i = 1'b0;
      idle(4);
      uart_rx_i = 1'b1;
      idle(60);
      checks++; if (fill_level_o !== 5'd0) begin failures++; $display("FAIL glitch_fill: got %0d expected 0", fill_level_o); end
      checks++; if (n_frame - f0 !== 0) begin failures++; $display("FAIL glitch_frame: got %0d expected 0", n_frame - f0); end
      send(8'h5A, FAST);
      idle(4);
      checks++; if (data_o !== 8'h5A || fill_level_o !== 5'd1) begin
         failures++; $display("FAIL glitch_after: got data=%h fill=%0d expected 5a/1", data_o, fill_level_o); end
      pop();
      $display("test_glitch: 4-tick low pulse rejected");
   endtask

   task automatic test_frame_error();
      int f0, o0;
      send(8'h81, FAST);
      idle(4);
      f0 = n_frame; o0 = n_over;
      send_frame(8'h55, FAST, 1'b0, ^8'h55, -1, 2'b00);
      idle(300);
      uart_rx_i = 1'b1;
      idle(40);
      checks++; if (n_frame - f0 !== 1) begin failures++; $display("FAIL frame_pulse: got %0d cycles expected 1", n_frame - f0); end
      checks++; if (fill_level_o !== 5'd1 || data_o !== 8'h81) begin
         failures++; $display("FAIL frame_fifo: got fill=%0d data=%h expected 1/81", fill_level_o, data_o); end
      checks++; if (n_over - o0 !== 0) begin failures++; $display("FAIL frame_overrun: got %0d expected 0", n_over - o0); end
      pop();
      $display("test_frame_error: 55 with low stop then break");
   endtask

   task automatic test_overrun();
      int o0;
      logic [7:0] b;
      o0 = n_over;
      for (int i = 0; i <= FIFO_DEPTH; i++) begin
         b = 8'(i * 13 + 7);
         send(b, FAST);
      end
      idle(4);
      checks++; if (fill_level_o !== 5'd16) begin failures++; $display("FAIL ovr_fill: got %0d expected 16", fill_level_o); end
      checks++; if (n_over - o0 !== 1) begin failures++; $display("FAIL ovr_pulse: got %0d expected 1", n_over - o0); end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         b = 8'(i * 13 + 7);
         checks++; if (data_o !== b) begin failures++; $display("FAIL ovr_data%0d: got %h expected %h", i, data_o, b); end
         pop();
      end
      checks++; if (empty_o !== 1'b1) begin failures++; $display("FAIL ovr_empty: got %b expected 1", empty_o); end
      $display("test_overrun: 17 bytes into depth 16");
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      int f0, p0;
      f0 = n_frame; p0 = n_par;
      send_frame(8'h01, FAST, 1'b1, 1'b0, -1, 2'b00);
      idle(4);
      checks++; if (n_par - p0 !== 1) begin failures++; $display("FAIL par_pulse: got %0d expected 1", n_par - p0); end
      checks++; if (fill_level_o !== 5'd0) begin failures++; $display("FAIL par_drop: got %0d expected 0", fill_level_o); end
      send_frame(8'h01, FAST, 1'b1, 1'b1, -1, 2'b00);
      idle(4);
      checks++; if (data_o !== 8'h01 || fill_level_o !== 5'd1) begin
         failures++; $display("FAIL par_good: got data=%h fill=%0d expected 01/1", data_o, fill_level_o); end
      pop();
      send_frame(8'h01, FAST, 1'b0, 1'b0, -1, 2'b00);
      uart_rx_i = 1'b1;
      idle(20);
      checks++; if (n_frame - f0 !== 1 || n_par - p0 !== 1) begin
         failures++; $display("FAIL par_precedence: got frame=%0d par=%0d expected 1/1", n_frame - f0, n_par - p0); end
      $display("test_parity: bad parity dropped, frame error wins");
   endtask
`endif

   task automatic test_reset_mid();
      send(8'h11, FAST);
      idle(4);
      checks++; if (fill_level_o !== 5'd1) begin failures++; $display("FAIL rmid_pre: got %0d expected 1", fill_level_o); end
      drive_bit(1'b0, FAST);
      drive_bit(1'b1, FAST);
      drive_bit(1'b0, 8);
      reset_i = 1'b1; uart_rx_i = 1'b1;
      @(negedge clock_i);
      reset_i = 1'b0;
      checks++; if (empty_o !== 1'b1 || fill_level_o !== 5'd0 || data_o !== 8'h00) begin
         failures++; $display("FAIL rmid_clear: got empty=%b fill=%0d data=%h expected 1/0/00", empty_o, fill_level_o, data_o); end
      idle(300);
      checks++; if (empty_o !== 1'b1) begin failures++; $display("FAIL rmid_quiet: got %b expected 1", empty_o); end
      send(8'h77, FAST);
      idle(4);
      checks++; if (data_o !== 8'h77 || fill_level_o !== 5'd1) begin
         failures++; $display("FAIL rmid_after: got data=%h fill=%0d expected 77/1", data_o, fill_level_o); end
      pop();
      $display("test_reset_mid: partial frame discarded");
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_baud_latch();
      test_glitch();
      test_frame_error();
      test_overrun();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
